// File: rtl/x1_multiplier_pkg.sv
// +-----------------------------------------------------------------------------+
// | Package    : mult_pkg                                                        |
// | Description: Shared constants and payload types for the multiplier stages.  |
// | Revision   : 1.0 - initial release                                          |
// +-----------------------------------------------------------------------------+
`default_nettype none

package mult_pkg;

    localparam int W    = 64;
    localparam int N_PP = 5;

    typedef logic [W-1:0] pp_vec_t;

    // Vector k occupies bits [64k+63:64k] of the packed vector array
    typedef struct packed {
        logic                 select_msb;
        logic                 signed_res;
        pp_vec_t [N_PP-1:0]   v;
    } x0x1_pld_t;

    typedef struct packed {
        logic    select_msb;
        logic    signed_res;
        pp_vec_t carry;
        pp_vec_t sum;
    } x1x2_pld_t;

endpackage

`default_nettype wire

// File: rtl/x1_multiplier_if.sv
// +-----------------------------------------------------------------------------+
// | Interface  : x1_multiplier_if                                               |
// | Description: x0x1 consumer side and x1x2 producer side of the X1 stage.     |
// |              master = surrounding pipeline (X0 FIFO, X2, flush source),     |
// |              slave  = the X1 stage itself.                                  |
// | Revision   : 1.0 - initial release                                          |
// +-----------------------------------------------------------------------------+
`default_nettype none

interface x1_multiplier_if #(
    parameter int W = 64
);
    logic [5*W-1:0] RES_RX0;
    logic           SELECT_MSB_RX0;
    logic           SIGNED_RES_RX0;
    logic           X0X1_EMPTY_SX0;
    logic           X0X1_POP_SX1;
    logic           FLUSH_SX1;
    logic           X1X2_POP_SX2;
    logic [2*W-1:0] RES_RX1;
    logic           SELECT_MSB_RX1;
    logic           SIGNED_RES_RX1;
    logic           X1X2_EMPTY_SX1;

    modport master (
        output RES_RX0, SELECT_MSB_RX0, SIGNED_RES_RX0, X0X1_EMPTY_SX0,
        output FLUSH_SX1, X1X2_POP_SX2,
        input  X0X1_POP_SX1, RES_RX1, SELECT_MSB_RX1, SIGNED_RES_RX1, X1X2_EMPTY_SX1
    );

    modport slave (
        input  RES_RX0, SELECT_MSB_RX0, SIGNED_RES_RX0, X0X1_EMPTY_SX0,
        input  FLUSH_SX1, X1X2_POP_SX2,
        output X0X1_POP_SX1, RES_RX1, SELECT_MSB_RX1, SIGNED_RES_RX1, X1X2_EMPTY_SX1
    );
endinterface

`default_nettype wire

// File: rtl/csa.sv
// +-----------------------------------------------------------------------------+
// | Module     : csa                                                            |
// | Description: 3:2 carry-save adder cell; carry out of the MSB is dropped.    |
// | Revision   : 1.0 - initial release                                          |
// +-----------------------------------------------------------------------------+
`default_nettype none

module csa #(
    parameter int WIDTH = 64
) (
    input  wire logic [WIDTH-1:0] a,
    input  wire logic [WIDTH-1:0] b,
    input  wire logic [WIDTH-1:0] c,
    output logic      [WIDTH-1:0] s0,
    output logic      [WIDTH-1:0] s1
);
    logic [WIDTH-1:0] maj;

    // Bitwise sum and majority carry, carry shifted one place left
    always_comb begin
        maj = (a & b) | (a & c) | (b & c);
        s0  = a ^ b ^ c;
        s1  = {maj[WIDTH-2:0], 1'b0};
    end
endmodule

`default_nettype wire

// File: rtl/x1x2_fifo.sv
// +-----------------------------------------------------------------------------+
// | Module     : x1x2_fifo                                                      |
// | Description: Circular-buffer FIFO with registered head, synchronous flush   |
// |              and asynchronous active-low reset. Payload type is generic.    |
// | Revision   : 1.0 - initial release                                          |
// +-----------------------------------------------------------------------------+
`default_nettype none

module x1x2_fifo #(
    parameter int  DEPTH = 2,
    parameter type T     = logic [7:0],
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  wire logic          clk,
    input  wire logic          reset_n,
    input  wire logic          push,
    input  wire logic          pop,
    input  wire logic          flush,
    input  wire T              wdata,
    output T                   rdata,
    output logic               full,
    output logic               empty,
    output logic [CW-1:0]      count
);
    T              mem_q [DEPTH];
    T              mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // Next-state: flush wins over push/pop and keeps entry contents
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_push  = push && !full  && !flush;
        do_pop   = pop  && !empty && !flush;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = PW'(wr_ptr_q + 1'b1);
            end
            if (do_pop) begin
                rd_ptr_d = PW'(rd_ptr_q + 1'b1);
            end
            if (do_push && !do_pop) begin
                count_d = count_q + CW'(1);
            end else if (!do_push && do_pop) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    // State registers; reset clears storage so the head reads as zero
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= T'('0);
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

`default_nettype wire

// File: rtl/x1_multiplier.sv
// +-----------------------------------------------------------------------------+
// | Module     : x1_multiplier                                                  |
// | Description: Multiplier stage X1. Pops five partial-sum vectors from the    |
// |              x0x1 FIFO, reduces them to sum/carry with three CSA levels and |
// |              pushes the pair plus flags into the internal x1x2 FIFO.        |
// |              Build option X1_FINAL_ADD_EN: store {0, sum+carry} instead.    |
// | Revision   : 1.0 - initial release                                          |
// +-----------------------------------------------------------------------------+
`default_nettype none

module x1_multiplier #(
    parameter int DEPTH = 2,
    parameter int W     = 64
) (
    input  wire logic           clk,
    input  wire logic           reset_n,
    input  wire logic [5*W-1:0] RES_RX0,
    input  wire logic           SELECT_MSB_RX0,
    input  wire logic           SIGNED_RES_RX0,
    input  wire logic           X0X1_EMPTY_SX0,
    output logic                X0X1_POP_SX1,
    input  wire logic           FLUSH_SX1,
    input  wire logic           X1X2_POP_SX2,
    output logic      [2*W-1:0] RES_RX1,
    output logic                SELECT_MSB_RX1,
    output logic                SIGNED_RES_RX1,
    output logic                X1X2_EMPTY_SX1
);
    import mult_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);

    x0x1_pld_t     rx0_pld;
    x1x2_pld_t     push_pld;
    x1x2_pld_t     head_pld;
    pp_vec_t       s1, c1, s2, c2, sum, carry;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    assign rx0_pld = {SELECT_MSB_RX0, SIGNED_RES_RX0, RES_RX0};

    csa #(.WIDTH(64)) u_csa_l1 (.a(rx0_pld.v[0]), .b(rx0_pld.v[1]), .c(rx0_pld.v[2]), .s0(s1),  .s1(c1));
    csa #(.WIDTH(64)) u_csa_l2 (.a(s1),           .b(c1),           .c(rx0_pld.v[3]), .s0(s2),  .s1(c2));
    csa #(.WIDTH(64)) u_csa_l3 (.a(s2),           .b(c2),           .c(rx0_pld.v[4]), .s0(sum), .s1(carry));

    // Pop only with room, no kill and reset released; a pop is also the push
    always_comb begin
        X0X1_POP_SX1 = reset_n && !X0X1_EMPTY_SX0 && !fifo_full && !FLUSH_SX1;
    end

    // Build the entry written into the x1x2 FIFO
    always_comb begin
        push_pld.select_msb = rx0_pld.select_msb;
        push_pld.signed_res = rx0_pld.signed_res;
`ifdef X1_FINAL_ADD_EN
        push_pld.carry      = '0;
        push_pld.sum        = sum + carry;
`else
        push_pld.carry      = carry;
        push_pld.sum        = sum;
`endif
    end

    x1x2_fifo #(
        .DEPTH (DEPTH),
        .T     (x1x2_pld_t)
    ) u_x1x2_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (X0X1_POP_SX1),
        .pop     (X1X2_POP_SX2),
        .flush   (FLUSH_SX1),
        .wdata   (push_pld),
        .rdata   (head_pld),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Head of the x1x2 FIFO drives the X2-facing outputs
    always_comb begin
        RES_RX1        = {head_pld.carry, head_pld.sum};
        SELECT_MSB_RX1 = head_pld.select_msb;
        SIGNED_RES_RX1 = head_pld.signed_res;
        X1X2_EMPTY_SX1 = fifo_empty;
    end

    logic unused_count;
    assign unused_count = ^fifo_count;
endmodule

`default_nettype wire

// File: doc/x1_multiplier.md
Name: x1_multiplier

Overview:
Second multiplier stage, X1. It is the consumer end of the x0x1 FIFO: it pops the five 64-bit partial-sum vectors and the two flag bits that the X0 stage pushes. It reduces the five vectors to a sum/carry pair through three carry-save levels. The pair and flags go into an internal x1x2 FIFO, which the X2 stage pops for the final carry-propagate add.

Parameters:
DEPTH, 2, number of x1x2 FIFO entries (power of two, at least 2)
W, 64, partial-sum vector width

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
RES_RX0  in  5*W  x0x1 head data: vector k at bits [64k+63:64k], k=0..4
SELECT_MSB_RX0  in  1  x0x1 head flag: result takes the high word
SIGNED_RES_RX0  in  1  x0x1 head flag: result sign handling
X0X1_EMPTY_SX0  in  1  x0x1 FIFO empty
X0X1_POP_SX1  out  1  pop request to the x0x1 FIFO
FLUSH_SX1  in  1  pipeline kill (branch/exception)
X1X2_POP_SX2  in  1  pop request from X2
RES_RX1  out  2*W  x1x2 head: carry in [127:64], sum in [63:0]
SELECT_MSB_RX1  out  1  x1x2 head flag
SIGNED_RES_RX1  out  1  x1x2 head flag
X1X2_EMPTY_SX1  out  1  x1x2 FIFO empty

Behaviour:
- CSA rule, same as the existing csa cell: S0 = A^B^C; S1 = {maj(A,B,C)[62:0],1'b0}. Carry-out past bit 63 is discarded, so all arithmetic is modulo 2^64.
- Reduction tree, combinational on RES_RX0 (v0..v4):
  - L1: csa(v0,v1,v2) gives s1,c1.
  - L2: csa(s1,c1,v3) gives s2,c2.
  - L3: csa(s2,c2,v4) gives sum,carry.
  - Invariant: sum+carry == v0+v1+v2+v3+v4 mod 2^64.
- Pop/push, evaluated in the same cycle:
  - X0X1_POP_SX1 = !X0X1_EMPTY_SX0 && !full && !FLUSH_SX1.
  - A push of {SELECT_MSB_RX0, SIGNED_RES_RX0, carry, sum} into the x1x2 FIFO happens exactly when X0X1_POP_SX1 is high.
  - full means count==DEPTH. A simultaneous X2 pop in that cycle does not lift full: no bypass, no push.
- Latency: an entry popped at edge N is visible on RES_RX1 with X1X2_EMPTY_SX1=0 after edge N. Throughput is one entry per cycle while X2 pops every cycle.
- x1x2 FIFO:
  - Circular buffer with write pointer, read pointer and count in 0..DEPTH; pointers wrap modulo DEPTH.
  - The outputs are the head entry and are registered.
  - A pop while empty is ignored.
  - Push and pop in the same cycle leave count unchanged.
- FLUSH_SX1 (synchronous):
  - That cycle: no x0x1 pop, no push; X1X2_POP_SX2 is ignored.
  - Next edge: count=0 and both pointers reset to 0; entry contents are kept.
  - Entries already in the x0x1 FIFO are left for X0 to flush.
- Reset (async, reset_n low):
  - count=0, pointers=0, all entries cleared.
  - X1X2_EMPTY_SX1=1, RES_RX1=0, SELECT_MSB_RX1=0, SIGNED_RES_RX1=0.
  - X0X1_POP_SX1=0 while reset_n is low.
  - Reset mid-operation drops all entries; the first pop after release is the first valid one.

Optional Feature:
X1_FINAL_ADD_EN.
- Defined: the stage also performs the carry-propagate add before the push. The entry stores {64'b0, sum+carry}, so RES_RX1[127:64]=0 and RES_RX1[63:0] is the full product bits. X2 must then pass the value through.
- Undefined: RES_RX1 = {carry, sum} as specified above.
- Handshake and latency are identical in both builds.

Decomposition:
- mult_pkg holds:
  - constant W=64 and constant N_PP=5;
  - typedef pp_vec_t (logic [W-1:0]);
  - struct x0x1_pld_t {select_msb, signed_res, pp_vec_t v[N_PP]};
  - struct x1x2_pld_t {select_msb, signed_res, pp_vec_t carry, sum}.
- The existing csa cell is instantiated three times.
- One new sub-module, x1x2_fifo: parameterised DEPTH and payload type, with push/pop/flush ports and full/empty/count outputs. It is kept separate for reuse by X2.

Test Plan:
- Single op:
  - Stimulus: v0..v4 = 1,2,3,4,5; flags = 1,0; x0x1 not empty for one cycle.
  - Response: X0X1_POP_SX1 high one cycle; next cycle X1X2_EMPTY_SX1=0 and carry+sum=15; flags 1,0; after X2 pop, empty=1.
- Wrap-around modulo 2^64:
  - Stimulus: all five vectors = 64'hFFFF_FFFF_FFFF_FFFF.
  - Response: sum+carry mod 2^64 = 64'hFFFF_FFFF_FFFF_FFFB.
- Backpressure:
  - Stimulus: X1X2_POP_SX2=0, x0x1 always non-empty.
  - Response: exactly 2 pops occur (DEPTH=2), then X0X1_POP_SX1 stays 0. Raising X2 pop for one cycle gives no new pop that cycle (full holds), one pop the next cycle, and entries leave in FIFO order.
- Streaming:
  - Stimulus: 8 back-to-back ops with X2 popping every cycle and count starting below full.
  - Response: a pop every cycle and outputs in order, each sum+carry matching a reference model.
- Flush:
  - Stimulus: 2 entries held, FLUSH_SX1 pulsed together with X2 pop and x0x1 non-empty.
  - Response: no x0x1 pop that cycle; next cycle X1X2_EMPTY_SX1=1.
- Reset mid-stream:
  - Stimulus: reset_n low asynchronously between edges while 1 entry is held.
  - Response: X1X2_EMPTY_SX1=1 and RES_RX1=0 immediately, before the next edge.
- X1_FINAL_ADD_EN build:
  - Stimulus: the single-op case.
  - Response: RES_RX1 = 128'd15.
